load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 32, memory data width; legal values 32 or 64.
REQ-002 SHALL have parameter ADDR_W, default 32, byte address width.
REQ-003 SHALL have parameter MEM_LATENCY, default 1, memory access cycles; legal range 1..15.
REQ-004 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have ports req_valid in 1 and req_ready out 1, the request handshake.
REQ-007 SHALL have ports req_we in 1 (store), req_size in 2 (00 byte, 01 half, 10 word, 11 dword) and req_unsigned in 1 (zero-extend load).
REQ-008 SHALL have ports req_addr in ADDR_W and req_wdata in DATA_W.
REQ-009 SHALL have ports rsp_valid out 1, rsp_rdata out DATA_W and rsp_fault out 1.
REQ-010 SHALL have ports mem_en out 1, mem_we out 1, mem_addr out ADDR_W (lane-aligned), mem_be out DATA_W/8, mem_wdata out DATA_W and mem_rdata in DATA_W.

Function
REQ-011 SHALL implement FSM IDLE -> ACCESS -> RESPOND -> IDLE; req_ready=1 only in IDLE.
REQ-012 SHALL accept a request on req_valid&req_ready; it SHALL register all request fields in that cycle (T).
REQ-013 SHALL hold ACCESS for exactly MEM_LATENCY cycles (T+1..T+MEM_LATENCY) with mem_en=1, mem_we=req_we and mem_addr/mem_be/mem_wdata stable throughout.
REQ-014 SHALL sample mem_rdata on the last ACCESS cycle and assert rsp_valid for exactly one cycle at T+MEM_LATENCY+1 (RESPOND).
REQ-015 SHALL derive byte offset = req_addr[log2(DATA_W/8)-1:0] and mem_addr = req_addr with the offset bits cleared.
REQ-016 SHALL drive mem_be = size mask (1,3,F,FF) shifted left by offset, and mem_wdata = req_wdata shifted left by offset*8.
REQ-017 SHALL extract the load lane at the offset and sign-extend it, or zero-extend it when req_unsigned=1; dword loads pass through.
REQ-018 SHALL return rsp_rdata=0 for stores; rsp_valid still pulses as the store acknowledge.
REQ-019 SHALL hold rsp_rdata and rsp_fault until the next response.
REQ-020 SHALL treat req_size=11 with DATA_W=32 as illegal.
REQ-021 SHALL keep mem_en=0 and mem_we=0 outside ACCESS.

Reset
REQ-022 SHALL on reset set state IDLE, req_ready=1 (from the following cycle), rsp_valid=0, rsp_rdata=0, rsp_fault=0, mem_en=0, mem_we=0, mem_be=0, mem_addr=0 and mem_wdata=0.
REQ-023 SHALL on reset asserted during ACCESS or RESPOND abort the transaction and return to IDLE, with mem_en/mem_we low and no rsp_valid on the next cycle.

Configuration
REQ-024 SHALL compile misalignment checking in under macro LSU_MISALIGN_TRAP_EN.
REQ-025 SHALL with the macro defined, on a misaligned access (half offset[0]!=0, word offset[1:0]!=0, dword offset!=0) or an illegal size, skip ACCESS, go directly to RESPOND at T+1 with rsp_fault=1 and rsp_rdata=0, and issue no memory access.
REQ-026 SHALL with the macro undefined, tie rsp_fault=0, force the misaligned offset bits to the natural alignment of the size, and treat an illegal size as word.

Structure
REQ-027 SHALL place the lsu_size_t enum (BYTE/HALF/WORD/DWORD) and the lsu_state_t enum in the shared types package, next to the existing control enums.
REQ-028 SHALL put lane extract/extend in one combinational sub-module, lsu_load_align; the FSM and latency counter SHALL stay in load_store_unit.

Verification
REQ-029 SHALL cover this case: MEM_LATENCY=1, load byte signed, addr 0x1003, mem_rdata 0x80AABBCC -> mem_be=1000, rsp_rdata=0xFFFFFF80, rsp_valid at T+2.
REQ-030 SHALL cover this case: MEM_LATENCY=3, store half, addr 0x0002, wdata 0x00001234 -> mem_be=1100, mem_wdata=0x12340000, mem_en high for 3 cycles, ack at T+4.
REQ-031 SHALL cover this case: load half unsigned, addr 0x0006, mem_rdata 0xBEEF0000 -> rsp_rdata=0x0000BEEF.
REQ-032 SHALL cover this case: with LSU_MISALIGN_TRAP_EN, load word at addr 0x0001 -> rsp_fault=1 at T+1 and mem_en never high; without the macro -> mem_addr=0x0000 and rsp_fault=0.
REQ-033 SHALL cover this case: reset asserted at T+2 of a MEM_LATENCY=4 load -> no rsp_valid, mem_en=0 next cycle, req_ready=1 after reset releases.
REQ-034 SHALL cover this case: DATA_W=64, load dword at addr 0x10 -> mem_be=0xFF and rsp_rdata=mem_rdata; back-to-back requests held valid are accepted only in IDLE.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared types for the load/store unit.
//   lsu_size_t  : access size encoding carried on req_size
//   lsu_state_t : request FSM states
//   size_mask   : byte-enable pattern for an access size at offset 0
//   align_mask  : offset bits that must be zero for a naturally aligned access
package load_store_unit_pkg;

  typedef enum logic [1:0] {
    BYTE  = 2'b00,
    HALF  = 2'b01,
    WORD  = 2'b10,
    DWORD = 2'b11
  } lsu_size_t;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ACCESS  = 2'b01,
    RESPOND = 2'b10
  } lsu_state_t;

  function automatic logic [7:0] size_mask(lsu_size_t s);
    case (s)
      BYTE:    size_mask = 8'h01;
      HALF:    size_mask = 8'h03;
      WORD:    size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
  endfunction

  function automatic logic [2:0] align_mask(lsu_size_t s);
    case (s)
      BYTE:    align_mask = 3'b000;
      HALF:    align_mask = 3'b001;
      WORD:    align_mask = 3'b011;
      default: align_mask = 3'b111;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_load_align.sv
// Load lane extraction and extension (purely combinational).
//   rdata    : full memory word as returned by memory
//   offset   : byte offset of the access within the word
//   size     : access size (lsu_size_t encoding)
//   zero_ext : 1 = zero-extend, 0 = sign-extend
//   data     : extended load result; dword passes the word through
module lsu_load_align
  import load_store_unit_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OFF_W  = 2
) (
  input  logic [DATA_W-1:0] rdata,
  input  logic [OFF_W-1:0]  offset,
  input  logic [1:0]        size,
  input  logic              zero_ext,
  output logic [DATA_W-1:0] data
);

  logic [DATA_W-1:0] lane;

  always_comb begin
    lane = rdata >> {offset, 3'b000};
    data = lane;
    case (size)
      BYTE:    data = DATA_W'({{56{~zero_ext & lane[7]}},  lane[7:0]});
      HALF:    data = DATA_W'({{48{~zero_ext & lane[15]}}, lane[15:0]});
      WORD:    data = DATA_W'({{32{~zero_ext & lane[31]}}, lane[31:0]});
      default: data = lane;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one request at a time, drives a fixed-latency
// memory for MEM_LATENCY cycles, then returns a one-cycle response.
//   clk, reset                   : clock, synchronous active-high reset
//   req_valid/req_ready          : request handshake (ready only in IDLE)
//   req_we/size/unsigned/addr/wdata : request fields
//   rsp_valid/rsp_rdata/rsp_fault   : response (data/fault held until next)
//   mem_en/we/addr/be/wdata/rdata   : lane-aligned memory port
// Optional feature: define LSU_MISALIGN_TRAP_EN to fault misaligned or
// illegal-size accesses instead of silently aligning them. Without it,
// rsp_fault stays 0.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_fault,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W/8-1:0]   mem_be,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata
);

  localparam int         BE_W     = DATA_W / 8;
  localparam int         OFF_W    = $clog2(BE_W);
  localparam logic [3:0] LAT_LAST = 4'(MEM_LATENCY - 1);

  lsu_state_t        state, state_next;
  logic [3:0]        cnt;
  logic              we_q, uns_q;
  lsu_size_t         size_q, size_eff;
  logic [OFF_W-1:0]  off_q, off_raw, off_eff;
  logic              accept, fault;
  logic [BE_W-1:0]   be_new;
  logic [DATA_W-1:0] wdata_new, load_data;

  assign off_raw = req_addr[OFF_W-1:0];
  assign accept  = req_valid & req_ready;

  // Request decode. Dword on a 32-bit bus degrades to word; the offset is
  // forced to natural alignment so the memory side never sees a straddle.
  always_comb begin
    size_eff = lsu_size_t'(req_size);
    if (DATA_W == 32 && size_eff == DWORD) size_eff = WORD;
    off_eff   = off_raw & ~OFF_W'(align_mask(size_eff));
    fault     = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    fault     = (off_raw != off_eff) ||
                (DATA_W == 32 && lsu_size_t'(req_size) == DWORD);
`endif
    be_new    = BE_W'(size_mask(size_eff)) << off_eff;
    wdata_new = req_wdata << {off_eff, 3'b000};
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    rsp_valid  = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        // A faulting request skips memory entirely.
        if (req_valid) state_next = fault ? RESPOND : ACCESS;
      end
      ACCESS: begin
        mem_en = 1'b1;
        mem_we = we_q;
        if (cnt == '0) state_next = RESPOND;
      end
      RESPOND: begin
        rsp_valid  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      we_q      <= 1'b0;
      uns_q     <= 1'b0;
      size_q    <= BYTE;
      off_q     <= '0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
      rsp_rdata <= '0;
      rsp_fault <= 1'b0;
    end else if (accept) begin
      cnt       <= LAT_LAST;
      we_q      <= req_we;
      uns_q     <= req_unsigned;
      size_q    <= size_eff;
      off_q     <= off_eff;
      mem_addr  <= req_addr & ~ADDR_W'(BE_W - 1);
      mem_be    <= be_new;
      mem_wdata <= wdata_new;
      if (fault) begin
        rsp_rdata <= '0;
        rsp_fault <= 1'b1;
      end
    end else if (state == ACCESS) begin
      if (cnt != '0) begin
        cnt <= cnt - 4'd1;
      end else begin
        // Last access cycle: capture read data for the RESPOND cycle.
        rsp_rdata <= we_q ? '0 : load_data;
        rsp_fault <= 1'b0;
      end
    end
  end

  lsu_load_align #(
    .DATA_W(DATA_W),
    .OFF_W (OFF_W)
  ) u_load_align (
    .rdata   (mem_rdata),
    .offset  (off_q),
    .size    (size_q),
    .zero_ext(uns_q),
    .data    (load_data)
  );

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic we, uns;
  logic [1:0]  size;
  logic [31:0] addr, wd32, rd_a, rd_b;
  logic [63:0] wd64, rd_c;
  logic v_a, v_b, v_c;

  logic a_ready, a_rsp_valid, a_rsp_fault, a_mem_en, a_mem_we;
  logic [31:0] a_rsp_rdata, a_mem_addr, a_mem_wdata;
  logic [3:0]  a_mem_be;
  logic b_ready, b_rsp_valid, b_rsp_fault, b_mem_en, b_mem_we;
  logic [31:0] b_rsp_rdata, b_mem_addr, b_mem_wdata;
  logic [3:0]  b_mem_be;
  logic c_ready, c_rsp_valid, c_rsp_fault, c_mem_en, c_mem_we;
  logic [63:0] c_rsp_rdata, c_mem_wdata;
  logic [31:0] c_mem_addr;
  logic [7:0]  c_mem_be;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] addr; logic [1:0] size; logic uns; logic [31:0] rd;
    logic [3:0] be; logic [31:0] maddr; logic [31:0] exp;
  } ld_vec_t;
  typedef struct {
    logic we; logic [31:0] addr; logic [1:0] size; logic [31:0] wd; logic [31:0] rd;
    logic [3:0] be; logic [31:0] maddr; logic [31:0] mwd; logic [31:0] exp;
  } st_vec_t;
  typedef struct {
    logic [31:0] addr; logic [1:0] size; logic [31:0] rd; logic bad;
    logic [3:0] be; logic [31:0] maddr; logic [31:0] exp;
  } ma_vec_t;
  typedef struct {
    logic [31:0] addr; logic [1:0] size; logic [63:0] rd;
    logic [7:0] be; logic [31:0] maddr; logic [63:0] exp;
  } dw_vec_t;

  ld_vec_t ld_tab [6];
  st_vec_t st_tab [3];
  ma_vec_t ma_tab [5];
  dw_vec_t dw_tab [2];

  always #5 clk = ~clk;

  load_store_unit #(.DATA_W(32), .ADDR_W(32), .MEM_LATENCY(1)) dut_a (
    .clk(clk), .reset(reset), .req_valid(v_a), .req_ready(a_ready), .req_we(we),
    .req_size(size), .req_unsigned(uns), .req_addr(addr), .req_wdata(wd32),
    .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata), .rsp_fault(a_rsp_fault),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_be(a_mem_be),
    .mem_wdata(a_mem_wdata), .mem_rdata(rd_a));

  load_store_unit #(.DATA_W(32), .ADDR_W(32), .MEM_LATENCY(3)) dut_b (
    .clk(clk), .reset(reset), .req_valid(v_b), .req_ready(b_ready), .req_we(we),
    .req_size(size), .req_unsigned(uns), .req_addr(addr), .req_wdata(wd32),
    .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_fault(b_rsp_fault),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_be(b_mem_be),
    .mem_wdata(b_mem_wdata), .mem_rdata(rd_b));

  load_store_unit #(.DATA_W(64), .ADDR_W(32), .MEM_LATENCY(4)) dut_c (
    .clk(clk), .reset(reset), .req_valid(v_c), .req_ready(c_ready), .req_we(we),
    .req_size(size), .req_unsigned(uns), .req_addr(addr), .req_wdata(wd64),
    .rsp_valid(c_rsp_valid), .rsp_rdata(c_rsp_rdata), .rsp_fault(c_rsp_fault),
    .mem_en(c_mem_en), .mem_we(c_mem_we), .mem_addr(c_mem_addr), .mem_be(c_mem_be),
    .mem_wdata(c_mem_wdata), .mem_rdata(rd_c));

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b exp 1", a_ready); end
    checks++; if (a_rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %b exp 0", a_rsp_valid); end
    checks++; if (a_rsp_rdata !== 32'h0) begin errors++; $display("FAIL rst_rsp_rdata: got %h exp 0", a_rsp_rdata); end
    checks++; if (a_rsp_fault !== 1'b0) begin errors++; $display("FAIL rst_rsp_fault: got %b exp 0", a_rsp_fault); end
    checks++; if (a_mem_en !== 1'b0) begin errors++; $display("FAIL rst_mem_en: got %b exp 0", a_mem_en); end
    checks++; if (a_mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we: got %b exp 0", a_mem_we); end
    checks++; if (a_mem_be !== 4'h0) begin errors++; $display("FAIL rst_mem_be: got %h exp 0", a_mem_be); end
    checks++; if (a_mem_addr !== 32'h0) begin errors++; $display("FAIL rst_mem_addr: got %h exp 0", a_mem_addr); end
    checks++; if (a_mem_wdata !== 32'h0) begin errors++; $display("FAIL rst_mem_wdata: got %h exp 0", a_mem_wdata); end
    checks++; if (c_mem_be !== 8'h0) begin errors++; $display("FAIL rst_c_mem_be: got %h exp 0", c_mem_be); end
    checks++; if (c_rsp_rdata !== 64'h0) begin errors++; $display("FAIL rst_c_rsp_rdata: got %h exp 0", c_rsp_rdata); end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL rst_b_ready: got %b exp 1", b_ready); end
    checks++; if (c_ready !== 1'b1) begin errors++; $display("FAIL rst_c_ready: got %b exp 1", c_ready); end
    @(posedge clk); #1;
  endtask

  // MEM_LATENCY=1 signed byte load from the top lane.
  task automatic test_load_byte();
    addr = 32'h1003; size = 2'b00; uns = 1'b0; we = 1'b0; rd_a = 32'h80AABBCC; v_a = 1'b1;
    @(negedge clk);
    checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL ldb_ready_T: got %b exp 1", a_ready); end
    @(posedge clk); #1; v_a = 1'b0;
    @(negedge clk);
    checks++; if (a_mem_en !== 1'b1) begin errors++; $display("FAIL ldb_mem_en: got %b exp 1", a_mem_en); end
    checks++; if (a_mem_we !== 1'b0) begin errors++; $display("FAIL ldb_mem_we: got %b exp 0", a_mem_we); end
    checks++; if (a_mem_be !== 4'b1000) begin errors++; $display("FAIL ldb_mem_be: got %b exp 1000", a_mem_be); end
    checks++; if (a_mem_addr !== 32'h1000) begin errors++; $display("FAIL ldb_mem_addr: got %h exp 00001000", a_mem_addr); end
    checks++; if (a_rsp_valid !== 1'b0) begin errors++; $display("FAIL ldb_early_valid: got %b exp 0", a_rsp_valid); end
    checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL ldb_busy_ready: got %b exp 0", a_ready); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (a_rsp_valid !== 1'b1) begin errors++; $display("FAIL ldb_valid_T2: got %b exp 1", a_rsp_valid); end
    checks++; if (a_rsp_rdata !== 32'hFFFFFF80) begin errors++; $display("FAIL ldb_rdata: got %h exp FFFFFF80", a_rsp_rdata); end
    checks++; if (a_mem_en !== 1'b0) begin errors++; $display("FAIL ldb_en_after: got %b exp 0", a_mem_en); end
    checks++; if (a_rsp_fault !== 1'b0) begin errors++; $display("FAIL ldb_fault: got %b exp 0", a_rsp_fault); end
    @(posedge clk); #1;
    rd_a = 32'h0;
    @(negedge clk);
    checks++; if (a_rsp_valid !== 1'b0) begin errors++; $display("FAIL ldb_valid_pulse: got %b exp 0", a_rsp_valid); end
    checks++; if (a_rsp_rdata !== 32'hFFFFFF80) begin errors++; $display("FAIL ldb_rdata_hold: got %h exp FFFFFF80", a_rsp_rdata); end
    checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL ldb_ready_back: got %b exp 1", a_ready); end
    @(posedge clk); #1;
  endtask

  // Lane extraction and sign/zero extension on the 32-bit, latency-1 unit.
  task automatic test_load_extend();
    ld_tab[0] = '{32'h6,    2'b01, 1'b1, 32'hBEEF0000, 4'hC, 32'h4,    32'h0000BEEF};
    ld_tab[1] = '{32'h6,    2'b01, 1'b0, 32'hBEEF0000, 4'hC, 32'h4,    32'hFFFFBEEF};
    ld_tab[2] = '{32'h1001, 2'b00, 1'b1, 32'h0000F100, 4'h2, 32'h1000, 32'h000000F1};
    ld_tab[3] = '{32'h2,    2'b00, 1'b0, 32'h007F0000, 4'h4, 32'h0,    32'h0000007F};
    ld_tab[4] = '{32'h0,    2'b01, 1'b0, 32'h12348001, 4'h3, 32'h0,    32'hFFFF8001};
    ld_tab[5] = '{32'h4,    2'b10, 1'b0, 32'h89ABCDEF, 4'hF, 32'h4,    32'h89ABCDEF};
    for (int i = 0; i < 6; i++) begin
      addr = ld_tab[i].addr; size = ld_tab[i].size; uns = ld_tab[i].uns; we = 1'b0;
      rd_a = ld_tab[i].rd; v_a = 1'b1;
      @(posedge clk); #1; v_a = 1'b0;
      @(negedge clk);
      checks++; if (a_mem_be !== ld_tab[i].be) begin errors++; $display("FAIL ldx_be[%0d]: got %h exp %h", i, a_mem_be, ld_tab[i].be); end
      checks++; if (a_mem_addr !== ld_tab[i].maddr) begin errors++; $display("FAIL ldx_addr[%0d]: got %h exp %h", i, a_mem_addr, ld_tab[i].maddr); end
      @(posedge clk); #1;
      @(negedge clk);
      checks++; if (a_rsp_valid !== 1'b1) begin errors++; $display("FAIL ldx_valid[%0d]: got %b exp 1", i, a_rsp_valid); end
      checks++; if (a_rsp_rdata !== ld_tab[i].exp) begin errors++; $display("FAIL ldx_rdata[%0d]: got %h exp %h", i, a_rsp_rdata, ld_tab[i].exp); end
      @(posedge clk); #1;
    end
  endtask

  // MEM_LATENCY=3: a load primes rsp_rdata, then stores must return zero.
  task automatic test_store();
    st_tab[0] = '{1'b0, 32'h8, 2'b10, 32'h0,        32'hDEADBEEF, 4'hF, 32'h8, 32'h0,        32'hDEADBEEF};
    st_tab[1] = '{1'b1, 32'h2, 2'b01, 32'h00001234, 32'hDEADBEEF, 4'hC, 32'h0, 32'h12340000, 32'h0};
    st_tab[2] = '{1'b1, 32'h3, 2'b00, 32'h123456AB, 32'hDEADBEEF, 4'h8, 32'h0, 32'hAB000000, 32'h0};
    for (int i = 0; i < 3; i++) begin
      addr = st_tab[i].addr; size = st_tab[i].size; uns = 1'b0; we = st_tab[i].we;
      wd32 = st_tab[i].wd; rd_b = st_tab[i].rd; v_b = 1'b1;
      @(posedge clk); #1; v_b = 1'b0;
      for (int k = 1; k <= 5; k++) begin
        @(negedge clk);
        checks++; if (b_mem_en !== (k <= 3)) begin errors++; $display("FAIL st_en[%0d] cycle %0d: got %b exp %b", i, k, b_mem_en, (k <= 3)); end
        checks++; if (b_rsp_valid !== (k == 4)) begin errors++; $display("FAIL st_valid[%0d] cycle %0d: got %b exp %b", i, k, b_rsp_valid, (k == 4)); end
        if (k <= 3) begin
          checks++; if (b_mem_we !== st_tab[i].we) begin errors++; $display("FAIL st_we[%0d] cycle %0d: got %b exp %b", i, k, b_mem_we, st_tab[i].we); end
          checks++; if (b_mem_be !== st_tab[i].be) begin errors++; $display("FAIL st_be[%0d] cycle %0d: got %h exp %h", i, k, b_mem_be, st_tab[i].be); end
          checks++; if (b_mem_addr !== st_tab[i].maddr) begin errors++; $display("FAIL st_addr[%0d] cycle %0d: got %h exp %h", i, k, b_mem_addr, st_tab[i].maddr); end
          checks++; if (b_mem_wdata !== st_tab[i].mwd) begin errors++; $display("FAIL st_wdata[%0d] cycle %0d: got %h exp %h", i, k, b_mem_wdata, st_tab[i].mwd); end
        end
        if (k == 4) begin
          checks++; if (b_rsp_rdata !== st_tab[i].exp) begin errors++; $display("FAIL st_rdata[%0d]: got %h exp %h", i, b_rsp_rdata, st_tab[i].exp); end
        end
        if (k > 3) begin
          checks++; if (b_mem_we !== 1'b0) begin errors++; $display("FAIL st_we_idle[%0d] cycle %0d: got %b exp 0", i, k, b_mem_we); end
        end
        @(posedge clk); #1;
      end
    end
    we = 1'b0;
  endtask

  // Misaligned / illegal-size handling; expectations depend on the build.
  task automatic test_misaligned();
    ma_tab[0] = '{32'h1, 2'b10, 32'h11223344, 1'b1, 4'hF, 32'h0, 32'h11223344};
    ma_tab[1] = '{32'h3, 2'b01, 32'h1234ABCD, 1'b1, 4'hC, 32'h0, 32'h00001234};
    ma_tab[2] = '{32'h8, 2'b11, 32'hCAFEF00D, 1'b1, 4'hF, 32'h8, 32'hCAFEF00D};
    ma_tab[3] = '{32'hC, 2'b10, 32'h0BADF00D, 1'b0, 4'hF, 32'hC, 32'h0BADF00D};
    ma_tab[4] = '{32'h5, 2'b00, 32'h0000EE00, 1'b0, 4'h2, 32'h4, 32'hFFFFFFEE};
    for (int i = 0; i < 5; i++) begin
      addr = ma_tab[i].addr; size = ma_tab[i].size; uns = 1'b0; we = 1'b0;
      rd_a = ma_tab[i].rd; v_a = 1'b1;
      @(posedge clk); #1; v_a = 1'b0;
      @(negedge clk);
      if (TRAP && ma_tab[i].bad) begin
        checks++; if (a_rsp_valid !== 1'b1) begin errors++; $display("FAIL ma_valid_T1[%0d]: got %b exp 1", i, a_rsp_valid); end
        checks++; if (a_rsp_fault !== 1'b1) begin errors++; $display("FAIL ma_fault[%0d]: got %b exp 1", i, a_rsp_fault); end
        checks++; if (a_rsp_rdata !== 32'h0) begin errors++; $display("FAIL ma_rdata0[%0d]: got %h exp 0", i, a_rsp_rdata); end
        checks++; if (a_mem_en !== 1'b0) begin errors++; $display("FAIL ma_no_en[%0d]: got %b exp 0", i, a_mem_en); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (a_rsp_valid !== 1'b0) begin errors++; $display("FAIL ma_valid_T2[%0d]: got %b exp 0", i, a_rsp_valid); end
        checks++; if (a_mem_en !== 1'b0) begin errors++; $display("FAIL ma_no_en_T2[%0d]: got %b exp 0", i, a_mem_en); end
        checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL ma_ready[%0d]: got %b exp 1", i, a_ready); end
      end else begin
        checks++; if (a_mem_en !== 1'b1) begin errors++; $display("FAIL ma_en[%0d]: got %b exp 1", i, a_mem_en); end
        checks++; if (a_mem_be !== ma_tab[i].be) begin errors++; $display("FAIL ma_be[%0d]: got %h exp %h", i, a_mem_be, ma_tab[i].be); end
        checks++; if (a_mem_addr !== ma_tab[i].maddr) begin errors++; $display("FAIL ma_addr[%0d]: got %h exp %h", i, a_mem_addr, ma_tab[i].maddr); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (a_rsp_valid !== 1'b1) begin errors++; $display("FAIL ma_valid[%0d]: got %b exp 1", i, a_rsp_valid); end
        checks++; if (a_rsp_fault !== 1'b0) begin errors++; $display("FAIL ma_nofault[%0d]: got %b exp 0", i, a_rsp_fault); end
        checks++; if (a_rsp_rdata !== ma_tab[i].exp) begin errors++; $display("FAIL ma_rdata[%0d]: got %h exp %h", i, a_rsp_rdata, ma_tab[i].exp); end
      end
      @(posedge clk); #1;
    end
  endtask

  // DATA_W=64, MEM_LATENCY=4: dword pass-through and upper-lane signed word.
  task automatic test_dword();
    dw_tab[0] = '{32'h10, 2'b11, 64'h0123456789ABCDEF, 8'hFF, 32'h10, 64'h0123456789ABCDEF};
    dw_tab[1] = '{32'h14, 2'b10, 64'h8000000100000000, 8'hF0, 32'h10, 64'hFFFFFFFF80000001};
    for (int i = 0; i < 2; i++) begin
      addr = dw_tab[i].addr; size = dw_tab[i].size; uns = 1'b0; we = 1'b0;
      rd_c = dw_tab[i].rd; v_c = 1'b1;
      @(posedge clk); #1; v_c = 1'b0;
      for (int k = 1; k <= 6; k++) begin
        @(negedge clk);
        checks++; if (c_mem_en !== (k <= 4)) begin errors++; $display("FAIL dw_en[%0d] cycle %0d: got %b exp %b", i, k, c_mem_en, (k <= 4)); end
        checks++; if (c_rsp_valid !== (k == 5)) begin errors++; $display("FAIL dw_valid[%0d] cycle %0d: got %b exp %b", i, k, c_rsp_valid, (k == 5)); end
        if (k == 1) begin
          checks++; if (c_mem_be !== dw_tab[i].be) begin errors++; $display("FAIL dw_be[%0d]: got %h exp %h", i, c_mem_be, dw_tab[i].be); end
          checks++; if (c_mem_addr !== dw_tab[i].maddr) begin errors++; $display("FAIL dw_addr[%0d]: got %h exp %h", i, c_mem_addr, dw_tab[i].maddr); end
        end
        if (k == 5) begin
          checks++; if (c_rsp_rdata !== dw_tab[i].exp) begin errors++; $display("FAIL dw_rdata[%0d]: got %h exp %h", i, c_rsp_rdata, dw_tab[i].exp); end
        end
        @(posedge clk); #1;
      end
    end
  endtask

  // Reset asserted during the second ACCESS cycle of a latency-4 load.
  task automatic test_reset_abort();
    addr = 32'h20; size = 2'b10; uns = 1'b0; we = 1'b0; rd_c = 64'h5555AAAA5555AAAA; v_c = 1'b1;
    @(posedge clk); #1; v_c = 1'b0;
    @(negedge clk);
    checks++; if (c_mem_en !== 1'b1) begin errors++; $display("FAIL ra_en_T1: got %b exp 1", c_mem_en); end
    @(posedge clk); #1; reset = 1'b1;
    @(negedge clk);
    checks++; if (c_mem_en !== 1'b1) begin errors++; $display("FAIL ra_en_T2: got %b exp 1", c_mem_en); end
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    checks++; if (c_mem_en !== 1'b0) begin errors++; $display("FAIL ra_en_T3: got %b exp 0", c_mem_en); end
    checks++; if (c_mem_we !== 1'b0) begin errors++; $display("FAIL ra_we_T3: got %b exp 0", c_mem_we); end
    checks++; if (c_rsp_valid !== 1'b0) begin errors++; $display("FAIL ra_valid_T3: got %b exp 0", c_rsp_valid); end
    checks++; if (c_ready !== 1'b1) begin errors++; $display("FAIL ra_ready: got %b exp 1", c_ready); end
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      checks++; if (c_rsp_valid !== 1'b0) begin errors++; $display("FAIL ra_no_valid cycle %0d: got %b exp 0", k, c_rsp_valid); end
      checks++; if (c_mem_en !== 1'b0) begin errors++; $display("FAIL ra_no_en cycle %0d: got %b exp 0", k, c_mem_en); end
    end
    checks++; if (c_rsp_rdata !== 64'h0) begin errors++; $display("FAIL ra_rdata: got %h exp 0", c_rsp_rdata); end
    @(posedge clk); #1;
  endtask

  // req_valid held high: accepts only in IDLE, one per 6-cycle transaction.
  task automatic test_back_to_back();
    int acc;
    acc = 0;
    addr = 32'h0; size = 2'b00; uns = 1'b0; we = 1'b0; rd_c = 64'h0; v_c = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (v_c && c_ready) acc++;
      checks++; if (c_ready !== ((k % 6) == 0)) begin errors++; $display("FAIL b2b_ready cycle %0d: got %b exp %b", k, c_ready, ((k % 6) == 0)); end
      checks++; if (c_mem_en !== ((k % 6) >= 1 && (k % 6) <= 4)) begin errors++; $display("FAIL b2b_en cycle %0d: got %b exp %b", k, c_mem_en, ((k % 6) >= 1 && (k % 6) <= 4)); end
      checks++; if (c_rsp_valid !== ((k % 6) == 5)) begin errors++; $display("FAIL b2b_valid cycle %0d: got %b exp %b", k, c_rsp_valid, ((k % 6) == 5)); end
      @(posedge clk); #1;
    end
    v_c = 1'b0;
    checks++; if (acc !== 2) begin errors++; $display("FAIL b2b_accepts: got %0d exp 2", acc); end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; v_a = 1'b0; v_b = 1'b0; v_c = 1'b0;
    we = 1'b0; uns = 1'b0; size = 2'b00; addr = '0; wd32 = '0; wd64 = '0;
    rd_a = '0; rd_b = '0; rd_c = '0;
    test_reset();
    test_load_byte();
    test_load_extend();
    test_store();
    test_misaligned();
    test_dword();
    test_reset_abort();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
